// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave):
// single-outstanding request/grant with a separate read-response strobe.
interface lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: single-outstanding data-memory bus master with byte-lane
// steering, alignment checking, load extension and a grant/response timeout.
module lsu #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [1:0]  op_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_i,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic [4:0]  rd_o,
   lsu_if.master       mem
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   state_e      state_q,    state_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q,   funct3_d;
   logic [1:0]  offs_q,     offs_d;
   logic [4:0]  rd_q,       rd_d;
   logic        err_q,      err_d;
   logic [31:0] cnt_q,      cnt_d;
   logic        we_q,       we_d;
   logic [31:0] addr_q,     addr_d;
   logic [3:0]  be_q,       be_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [31:0] rdata_q,    rdata_d;
   logic [4:0]  rd_out_q,   rd_out_d;

   logic        illegal;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_val;
   logic [31:0] cnt_next;
   logic        timeout_hit;

   // Request decode: legality, byte enables and lane-replicated store data.
   always_comb begin
      illegal   = 1'b0;
      be_new    = 4'b1111;
      wdata_new = wdata_i;
      case (op_i)
         OP_LOAD:  illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
         OP_STORE: illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
         default:  illegal = 1'b1;
      endcase
      if ((funct3_i[1:0] == 2'b01) && addr_i[0])
         illegal = 1'b1;
      if ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00))
         illegal = 1'b1;
      case (funct3_i[1:0])
         2'b00: begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata_i[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = wdata_i;
         end
      endcase
   end

   always_comb begin
      load_byte = 8'(mem.mem_rdata >> {offs_q, 3'b000});
      load_half = offs_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_val = {{16{load_half[15]}}, load_half};
         3'b010:  load_val = mem.mem_rdata;
         3'b100:  load_val = {24'd0, load_byte};
         3'b101:  load_val = {16'd0, load_half};
         default: load_val = 32'd0;
      endcase
   end

   // A zero TIMEOUT_CYC means wait forever for grant or response.
   assign cnt_next    = cnt_q + 32'd1;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_next == 32'(TIMEOUT_CYC));

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      offs_d     = offs_q;
      rd_d       = rd_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      rd_out_d   = rd_out_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               is_store_d = (op_i == OP_STORE);
               funct3_d   = funct3_i;
               offs_d     = addr_i[1:0];
               rd_d       = rd_i;
               if (illegal) begin
                  err_d    = 1'b1;
                  rdata_d  = 32'd0;
                  rd_out_d = rd_i;
                  state_d  = DONE;
               end else begin
                  err_d   = 1'b0;
                  cnt_d   = 32'd0;
                  we_d    = (op_i == OP_STORE);
                  addr_d  = {addr_i[31:2], 2'b00};
                  be_d    = be_new;
                  wdata_d = wdata_new;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (mem.mem_gnt) begin
               cnt_d = 32'd0;
               if (is_store_q) begin
                  rdata_d  = 32'd0;
                  rd_out_d = rd_q;
                  state_d  = DONE;
               end else begin
                  state_d = RESP;
               end
            end else if (timeout_hit) begin
               err_d    = 1'b1;
               rdata_d  = 32'd0;
               rd_out_d = rd_q;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_next;
            end
         end
         RESP: begin
            if (mem.mem_rvalid) begin
               rdata_d  = load_val;
               rd_out_d = rd_q;
               state_d  = DONE;
            end else if (timeout_hit) begin
               err_d    = 1'b1;
               rdata_d  = 32'd0;
               rd_out_d = rd_q;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= 3'd0;
         offs_q     <= 2'd0;
         rd_q       <= 5'd0;
         err_q      <= 1'b0;
         cnt_q      <= 32'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         rd_out_q   <= 5'd0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         offs_q     <= offs_d;
         rd_q       <= rd_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         rd_out_q   <= rd_out_d;
      end
   end

   // Request and status follow the state directly so reset drops them at once.
   assign ready_o       = (state_q == IDLE);
   assign done_o        = (state_q == DONE);
   assign err_o         = (state_q == DONE) && err_q;
   assign rdata_o       = rdata_q;
   assign rd_o          = rd_out_q;
   assign mem.mem_req   = (state_q == REQ);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed table, reset sequences and randomized
// transactions checked against a behavioural model of the load/store rules.
module tb_lsu;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i;
   logic        ready_o;
   logic [1:0]  op_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [4:0]  rd_i;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;
   logic [4:0]  rd_o;

   int nCompared   = 0;
   int nMismatched = 0;

   lsu_if bus();

   lsu #(.TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .funct3_i (funct3_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .rd_i     (rd_i),
      .done_o   (done_o),
      .err_o    (err_o),
      .rdata_o  (rdata_o),
      .rd_o     (rd_o),
      .mem      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      logic [4:0]  rd;
      int          gd;
      int          rv;
      logic        expErr;
      logic [31:0] expData;
      int          expDone;
      int          expReq;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic        expWe;
      logic [31:0] expWdata;
   } txn_t;

   function automatic txn_t mkTxn(input logic [1:0] op, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, input logic [4:0] rd,
                                  input int gd, input int rv, input logic expErr,
                                  input logic [31:0] expData, input int expDone,
                                  input int expReq, input logic [31:0] expAddr,
                                  input logic [3:0] expBe, input logic expWe,
                                  input logic [31:0] expWdata);
      txn_t t;
      t.op = op; t.f3 = f3; t.addr = addr; t.wdata = wdata; t.word = word;
      t.rd = rd; t.gd = gd; t.rv = rv; t.expErr = expErr; t.expData = expData;
      t.expDone = expDone; t.expReq = expReq; t.expAddr = expAddr;
      t.expBe = expBe; t.expWe = expWe; t.expWdata = expWdata;
      return t;
   endfunction

   // Access size, legality, lane data and timing derived from the ISA rules.
   function automatic txn_t refModel(input txn_t t);
      txn_t        r = t;
      int unsigned n;
      int unsigned a;
      logic        legal;
      logic [31:0] v;
      a = t.addr % 4;
      n = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
      legal = ((t.op == 2'd1) && (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              ((t.op == 2'd2) && (t.f3 inside {3'd0, 3'd1, 3'd2}));
      if (a % n != 0) legal = 1'b0;
      r.expAddr  = t.addr - a;
      r.expBe    = 4'(((1 << n) - 1) << a);
      r.expWe    = (t.op == 2'd2);
      r.expWdata = (n == 1) ? (t.wdata % 256) * 32'h01010101 :
                   (n == 2) ? (t.wdata % 65536) * 32'h00010001 : t.wdata;
      r.expErr   = 1'b1;
      r.expData  = 32'd0;
      if (!legal) begin
         r.expDone = 1; r.expReq = 0;
      end else if (t.gd >= int'(TO)) begin
         r.expDone = int'(TO) + 1; r.expReq = int'(TO);
      end else if (t.op == 2'd2) begin
         r.expErr = 1'b0; r.expDone = t.gd + 2; r.expReq = t.gd + 1;
      end else if (t.rv >= int'(TO)) begin
         r.expDone = t.gd + int'(TO) + 2; r.expReq = t.gd + 1;
      end else begin
         r.expErr  = 1'b0;
         r.expDone = t.gd + t.rv + 3;
         r.expReq  = t.gd + 1;
         v = t.word / (32'd1 << (8 * a));
         if (n == 1) begin
            v = v % 256;
            if (t.f3 == 3'd0 && v >= 128) v = v - 256;
         end else if (n == 2) begin
            v = v % 65536;
            if (t.f3 == 3'd1 && v >= 32768) v = v - 65536;
         end
         r.expData = v;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Runs one transaction from an IDLE negedge, acting as the memory and
   // throwing ignored noise at valid_i/mem_rvalid while the LSU is busy.
   task automatic applyStimulus(input txn_t t, input string tag);
      int          cyc;
      int          reqCnt;
      int          respCnt;
      int          doneCyc;
      logic        granted;
      logic        payloadOk;
      logic        seenDone;
      logic        gotErr;
      logic [31:0] gotData;
      logic [4:0]  gotRd;
      checkOutput($sformatf("%s.ready", tag), 32'(ready_o), 32'd1);
      valid_i = 1'b1; op_i = t.op; funct3_i = t.f3; addr_i = t.addr;
      wdata_i = t.wdata; rd_i = t.rd;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      reqCnt = 0; respCnt = 0; doneCyc = -1; granted = 1'b0; payloadOk = 1'b1;
      seenDone = 1'b0; gotErr = 1'b0; gotData = 32'd0; gotRd = 5'd0; cyc = 0;
      while (!seenDone && cyc < 40) begin
         @(negedge clk);
         cyc++;
         valid_i  = 1'($urandom_range(0, 1));
         op_i     = 2'($urandom);
         funct3_i = 3'($urandom);
         addr_i   = $urandom;
         wdata_i  = $urandom;
         rd_i     = 5'($urandom);
         bus.mem_gnt    = 1'b0;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = $urandom;
         if (done_o) begin
            seenDone = 1'b1; doneCyc = cyc;
            gotErr = err_o; gotData = rdata_o; gotRd = rd_o;
            if (bus.mem_req) payloadOk = 1'b0;
         end else if (bus.mem_req) begin
            reqCnt++;
            if (bus.mem_addr !== t.expAddr || bus.mem_be !== t.expBe ||
                bus.mem_we !== t.expWe || (t.expWe && bus.mem_wdata !== t.expWdata))
               payloadOk = 1'b0;
            if (reqCnt == t.gd + 1) begin
               bus.mem_gnt = 1'b1; granted = 1'b1;
            end else begin
               bus.mem_rvalid = 1'($urandom_range(0, 1));
            end
         end else if (granted) begin
            respCnt++;
            if (respCnt == t.rv + 1) begin
               bus.mem_rvalid = 1'b1; bus.mem_rdata = t.word;
            end
         end
      end
      if (!seenDone) begin
         nCompared++; nMismatched++;
         $display("[TB] FAIL %s.noDone: got no done_o within 40 cycles required done_o at cycle %0d", tag, t.expDone);
      end else begin
         checkOutput($sformatf("%s.err", tag), 32'(gotErr), 32'(t.expErr));
         checkOutput($sformatf("%s.rdata", tag), gotData, t.expData);
         checkOutput($sformatf("%s.rd", tag), 32'(gotRd), 32'(t.rd));
         checkOutput($sformatf("%s.doneCycle", tag), 32'(doneCyc), 32'(t.expDone));
         checkOutput($sformatf("%s.reqCycles", tag), 32'(reqCnt), 32'(t.expReq));
         checkOutput($sformatf("%s.payload", tag), 32'(payloadOk), 32'd1);
      end
      @(negedge clk);
      checkOutput($sformatf("%s.donePulse", tag), 32'(done_o), 32'd0);
      checkOutput($sformatf("%s.readyAfter", tag), 32'(ready_o), 32'd1);
      valid_i = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
   endtask

   initial begin
      txn_t        tbl[13];
      txn_t        t;
      int unsigned sz;
      valid_i = 1'b0; op_i = 2'd0; funct3_i = 3'd0; addr_i = 32'd0;
      wdata_i = 32'd0; rd_i = 5'd0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;

      tbl[0]  = mkTxn(2'b10, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 5'd1, 0, 0, 1'b0, 32'h0, 2, 1, 32'h1000, 4'b1000, 1'b1, 32'hDDDDDDDD);
      tbl[1]  = mkTxn(2'b01, 3'b000, 32'h2002, 32'h0, 32'h12F45678, 5'd2, 0, 0, 1'b0, 32'hFFFFFFF4, 3, 1, 32'h2000, 4'b0100, 1'b0, 32'h0);
      tbl[2]  = mkTxn(2'b01, 3'b100, 32'h2002, 32'h0, 32'h12F45678, 5'd3, 0, 0, 1'b0, 32'h000000F4, 3, 1, 32'h2000, 4'b0100, 1'b0, 32'h0);
      tbl[3]  = mkTxn(2'b01, 3'b001, 32'h2002, 32'h0, 32'h12F45678, 5'd4, 0, 0, 1'b0, 32'h000012F4, 3, 1, 32'h2000, 4'b1100, 1'b0, 32'h0);
      tbl[4]  = mkTxn(2'b01, 3'b010, 32'h3000, 32'h0, 32'hCAFEF00D, 5'd5, 3, 1, 1'b0, 32'hCAFEF00D, 7, 4, 32'h3000, 4'b1111, 1'b0, 32'h0);
      tbl[5]  = mkTxn(2'b01, 3'b010, 32'h3002, 32'h0, 32'h0, 5'd6, 0, 0, 1'b1, 32'h0, 1, 0, 32'h0, 4'b0, 1'b0, 32'h0);
      tbl[6]  = mkTxn(2'b10, 3'b001, 32'h3001, 32'h0, 32'h0, 5'd7, 0, 0, 1'b1, 32'h0, 1, 0, 32'h0, 4'b0, 1'b1, 32'h0);
      tbl[7]  = mkTxn(2'b11, 3'b010, 32'h3000, 32'h0, 32'h0, 5'd8, 0, 0, 1'b1, 32'h0, 1, 0, 32'h0, 4'b0, 1'b0, 32'h0);
      tbl[8]  = mkTxn(2'b01, 3'b010, 32'h4000, 32'h0, 32'h0, 5'd9, 99, 0, 1'b1, 32'h0, 5, 4, 32'h4000, 4'b1111, 1'b0, 32'h0);
      tbl[9]  = mkTxn(2'b01, 3'b010, 32'h4004, 32'h0, 32'h0, 5'd10, 0, 9, 1'b1, 32'h0, 6, 1, 32'h4004, 4'b1111, 1'b0, 32'h0);
      tbl[10] = mkTxn(2'b01, 3'b001, 32'h2000, 32'h0, 32'h00008001, 5'd11, 1, 0, 1'b0, 32'hFFFF8001, 4, 2, 32'h2000, 4'b0011, 1'b0, 32'h0);
      tbl[11] = mkTxn(2'b01, 3'b101, 32'h2002, 32'h0, 32'h80010000, 5'd12, 0, 2, 1'b0, 32'h00008001, 5, 1, 32'h2000, 4'b1100, 1'b0, 32'h0);
      tbl[12] = mkTxn(2'b10, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 5'd13, 2, 0, 1'b0, 32'h0, 4, 3, 32'h2000, 4'b1100, 1'b1, 32'hABCDABCD);

      repeat (2) @(negedge clk);
      checkOutput("reset.ready", 32'(ready_o), 32'd1);
      checkOutput("reset.done", 32'(done_o), 32'd0);
      checkOutput("reset.err", 32'(err_o), 32'd0);
      checkOutput("reset.req", 32'(bus.mem_req), 32'd0);
      checkOutput("reset.be", 32'(bus.mem_be), 32'd0);
      checkOutput("reset.addr", bus.mem_addr, 32'd0);
      checkOutput("reset.rdata", rdata_o, 32'd0);
      checkOutput("reset.rd", 32'(rd_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++)
         applyStimulus(tbl[i], $sformatf("vec%0d", i));

      $display("[TB] reset in REQ and RESP");
      valid_i = 1'b1; op_i = 2'b01; funct3_i = 3'b010; addr_i = 32'h5000; rd_i = 5'd20;
      @(negedge clk);
      valid_i = 1'b0;
      checkOutput("rstReq.reqUp", 32'(bus.mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstReq.reqDrop", 32'(bus.mem_req), 32'd0);
      checkOutput("rstReq.ready", 32'(ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      valid_i = 1'b1; op_i = 2'b01; funct3_i = 3'b010; addr_i = 32'h5004; rd_i = 5'd21;
      @(negedge clk);
      valid_i = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      checkOutput("rstResp.busy", 32'(ready_o), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("rstResp.req", 32'(bus.mem_req), 32'd0);
      checkOutput("rstResp.done", 32'(done_o), 32'd0);
      checkOutput("rstResp.ready", 32'(ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55AA55AA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rstResp.stale%0d", i), 32'(done_o), 32'd0);
      end
      bus.mem_rvalid = 1'b0;

      for (int i = 0; i < 150; i++) begin
         t.op    = 2'($urandom_range(0, 9) == 0 ? $urandom_range(0, 3) : $urandom_range(1, 2));
         t.f3    = 3'($urandom);
         t.addr  = $urandom;
         sz      = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
         if ($urandom_range(0, 3) != 0) t.addr = t.addr - (t.addr % sz);
         t.wdata = $urandom;
         t.word  = $urandom;
         t.rd    = 5'($urandom);
         t.gd    = $urandom_range(0, 5);
         t.rv    = $urandom_range(0, 5);
         t = refModel(t);
         applyStimulus(t, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
